poc_top: RTL and testbench

Self-contained parallel-output-controller (POC) subsystem. A processor model moves bytes from `i_data` into the POC, and the POC forwards them to a printer model over a ready/transfer handshake. The processor learns that the POC is free either by polling the status register (`i_mode`=0) or from an active-low interrupt (`i_mode`=1). All internal buses are exported so the bench can watch each transaction.

---
 rtl/poc_pkg.sv | 38 +++
 rtl/poc_if.sv | 27 ++
 rtl/poc_ctrl.sv | 96 +++++++++
 rtl/poc_top.sv | 137 +++++++++++++
 tb/tb_poc_top.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/poc_pkg.sv
// Shared definitions for the parallel-output-controller slice: register map,
// SR bit positions and the state encodings of the POC, processor and printer.
package poc_pkg;

  localparam logic ADDR_SR = 1'b0;
  localparam logic ADDR_BR = 1'b1;

  localparam int unsigned SR_RDY = 7;
  localparam int unsigned SR_IE  = 0;

  typedef enum logic [1:0] {
    POC_IDLE,
    POC_WAIT,
    POC_SEND
  } poc_state_e;

  typedef enum logic [2:0] {
    CPU_DISPATCH,
    CPU_ENABLE,
    CPU_POLL,
    CPU_IRQWAIT,
    CPU_WRBR,
    CPU_CLRSR
  } cpu_state_e;

  typedef enum logic {
    PRN_READY,
    PRN_BUSY
  } prn_state_e;

  // Assemble an SR image; bits 6:1 are hard zero.
  function automatic logic [7:0] sr_word(input logic rdy, input logic ie);
    sr_word         = '0;
    sr_word[SR_RDY] = rdy;
    sr_word[SR_IE]  = ie;
  endfunction

endpackage

// File: rtl/poc_if.sv
// Processor-side register bus of the POC: direction, register select,
// write/read data and the active-low interrupt back to the processor.
interface poc_bus_if;

  logic       rw;
  logic       addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       irq;

  modport master (
    output rw,
    output addr,
    output wdata,
    input  rdata,
    input  irq
  );

  modport slave (
    input  rw,
    input  addr,
    input  wdata,
    output rdata,
    output irq
  );

endinterface

// File: rtl/poc_ctrl.sv
// POC register file (SR, BR), combinational read mux, interrupt and the
// IDLE/WAIT/SEND transfer FSM towards the printer.
module poc_ctrl
  import poc_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  poc_bus_if.slave   bus,
  input  logic       prn_rdy_i,
  output logic       tr_o,
  output logic [7:0] pd_o
);

  poc_state_e state_q;
  logic       tr_q;
  logic       sr_rdy_q, sr_rdy_d;
  logic       sr_ie_q, sr_ie_d;
  logic [7:0] br_q, br_d;
  logic [7:0] sr;
  logic       wr_sr, wr_br;

  assign sr    = sr_word(sr_rdy_q, sr_ie_q);
  assign wr_sr = bus.rw && (bus.addr == ADDR_SR);
  assign wr_br = bus.rw && (bus.addr == ADDR_BR);

  always_comb begin
    sr_rdy_d = sr_rdy_q;
    sr_ie_d  = sr_ie_q;
    br_d     = br_q;
    if (wr_sr) begin
      sr_ie_d  = bus.wdata[SR_IE];
      sr_rdy_d = sr_rdy_q & bus.wdata[SR_RDY];
    end
    if (wr_br) begin
      br_d = bus.wdata;
    end
    // The SEND-cycle set of the ready flag overrides a same-cycle SR write.
    if (tr_q) begin
      sr_rdy_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_rdy_q <= 1'b1;
      sr_ie_q  <= 1'b0;
      br_q     <= '0;
    end else begin
      sr_rdy_q <= sr_rdy_d;
      sr_ie_q  <= sr_ie_d;
      br_q     <= br_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= POC_IDLE;
      tr_q    <= 1'b0;
    end else begin
      tr_q <= 1'b0;
      case (state_q)
        POC_IDLE: begin
          if (!sr_rdy_q) begin
            if (prn_rdy_i) begin
              state_q <= POC_SEND;
              tr_q    <= 1'b1;
            end else begin
              state_q <= POC_WAIT;
            end
          end
        end
        POC_WAIT: begin
          if (prn_rdy_i) begin
            state_q <= POC_SEND;
            tr_q    <= 1'b1;
          end
        end
        POC_SEND: state_q <= POC_IDLE;
        default:  state_q <= POC_IDLE;
      endcase
    end
  end

  // Read bus is forced quiet while reset is held so both data buses read 0.
  always_comb begin
    bus.rdata = '0;
    if (rst_ni && !bus.rw) begin
      bus.rdata = (bus.addr == ADDR_SR) ? sr : br_q;
    end
  end

  assign bus.irq = ~(sr_rdy_q & sr_ie_q);
  assign tr_o    = tr_q;
  assign pd_o    = br_q;

endmodule

// File: rtl/poc_top.sv
// POC subsystem: processor model, POC controller and printer model, with the
// processor bus and printer handshake exported for observation.
module poc_top
  import poc_pkg::*;
#(
  parameter int unsigned PRINT_CYCLES = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_data,
  input  logic       i_mode,
  output logic       o_tr,
  output logic [7:0] o_pd,
  output logic       o_rdy,
  output logic [7:0] o_data,
  output logic       o_rw,
  output logic       o_addr,
  output logic       o_irq,
  output logic [7:0] o_data_poc_to_processor,
  output logic [7:0] o_data_processor_to_poc
);

  localparam int unsigned CNT_W = $clog2(PRINT_CYCLES + 1);

  poc_bus_if bus ();

  cpu_state_e       cpu_q;
  logic             ie_q;
  prn_state_e       prn_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       prn_data_q;
  logic             tr;
  logic [7:0]       pd;
  logic             prn_rdy;

  poc_ctrl u_ctrl (
    .clk_i     (i_clk),
    .rst_ni    (i_rst_n),
    .bus       (bus),
    .prn_rdy_i (prn_rdy),
    .tr_o      (tr),
    .pd_o      (pd)
  );

  // Processor bus drive decoded from the processor state.
  always_comb begin
    bus.rw    = 1'b0;
    bus.addr  = ADDR_SR;
    bus.wdata = '0;
    case (cpu_q)
      CPU_ENABLE: begin
        bus.rw    = 1'b1;
        bus.addr  = ADDR_SR;
        bus.wdata = sr_word(1'b1, i_mode);
      end
      CPU_POLL: begin
        bus.rw   = 1'b0;
        bus.addr = ADDR_SR;
      end
      CPU_WRBR: begin
        bus.rw    = 1'b1;
        bus.addr  = ADDR_BR;
        bus.wdata = i_data;
      end
      CPU_CLRSR: begin
        bus.rw    = 1'b1;
        bus.addr  = ADDR_SR;
        bus.wdata = sr_word(1'b0, ie_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cpu_q <= CPU_DISPATCH;
      ie_q  <= 1'b0;
    end else begin
      case (cpu_q)
        CPU_DISPATCH: begin
          if (ie_q != i_mode) cpu_q <= CPU_ENABLE;
          else if (i_mode)    cpu_q <= CPU_IRQWAIT;
          else                cpu_q <= CPU_POLL;
        end
        CPU_ENABLE: begin
          ie_q  <= i_mode;
          cpu_q <= CPU_DISPATCH;
        end
        CPU_POLL:    cpu_q <= bus.rdata[SR_RDY] ? CPU_WRBR : CPU_DISPATCH;
        CPU_IRQWAIT: if (!bus.irq) cpu_q <= CPU_WRBR;
        CPU_WRBR:    cpu_q <= CPU_CLRSR;
        CPU_CLRSR:   cpu_q <= CPU_DISPATCH;
        default:     cpu_q <= CPU_DISPATCH;
      endcase
    end
  end

  // Printer: a strobe is only honoured while ready; the counter spans the busy time.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prn_q      <= PRN_READY;
      cnt_q      <= '0;
      prn_data_q <= '0;
    end else begin
      case (prn_q)
        PRN_READY: begin
          if (tr) begin
            prn_data_q <= pd;
            cnt_q      <= CNT_W'(PRINT_CYCLES);
            prn_q      <= PRN_BUSY;
          end
        end
        PRN_BUSY: begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_q <= '0;
            prn_q <= PRN_READY;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  assign prn_rdy = (prn_q == PRN_READY);

  assign o_tr                    = tr;
  assign o_pd                    = pd;
  assign o_rdy                   = prn_rdy;
  assign o_data                  = prn_data_q;
  assign o_rw                    = bus.rw;
  assign o_addr                  = bus.addr;
  assign o_irq                   = bus.irq;
  assign o_data_poc_to_processor = bus.rdata;
  assign o_data_processor_to_poc = bus.wdata;

endmodule

// File: tb/tb_poc_top.sv
// Self-checking bench for poc_top: BR writes feed a scoreboard of expected
// printer bytes; per-scenario tasks check bus sequencing, IRQ and reset.
module tb_poc_top;

  localparam int unsigned PC = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tr, rdy, rw, addr, irq;
  logic [7:0] pd, pdata, rdp, wdp;

  int checks = 0;
  int failures = 0;

  logic [7:0] exp_q[$];
  logic       pend_valid = 1'b0;
  logic [7:0] pend_data = 8'h00;
  logic [7:0] mon_e;
  int         low_cnt = 0;
  bit         seen [0:255];

  poc_bus_if mon ();

  poc_top #(.PRINT_CYCLES(PC)) dut (
    .i_clk                   (clk),
    .i_rst_n                 (rst_n),
    .i_data                  (din),
    .i_mode                  (mode),
    .o_tr                    (tr),
    .o_pd                    (pd),
    .o_rdy                   (rdy),
    .o_data                  (pdata),
    .o_rw                    (rw),
    .o_addr                  (addr),
    .o_irq                   (irq),
    .o_data_poc_to_processor (rdp),
    .o_data_processor_to_poc (wdp)
  );

  assign mon.rw    = rw;
  assign mon.addr  = addr;
  assign mon.wdata = wdp;
  assign mon.rdata = rdp;
  assign mon.irq   = irq;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every BR write queues the byte the bench drove; every printer
  // strobe must carry the oldest queued byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      pend_valid = 1'b0;
      low_cnt = 0;
    end else begin
      if (pend_valid) begin
        checks++;
        if (pdata !== pend_data || rdy !== 1'b0) begin
          failures++;
          $display("FAIL prn_latch: o_data=%h o_rdy=%b required o_data=%h o_rdy=0", pdata, rdy, pend_data);
        end
        pend_valid = 1'b0;
      end
      if (mon.rw === 1'b1 && mon.addr === 1'b1) begin
        exp_q.push_back(din);
        checks++;
        if (mon.wdata !== din) begin
          failures++;
          $display("FAIL br_write: wdata=%h required %h", mon.wdata, din);
        end
      end
      if (tr === 1'b1) begin
        checks++;
        if (rdy !== 1'b1) begin
          failures++;
          $display("FAIL tr_while_busy: o_rdy=%b required 1", rdy);
        end
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_tr: o_pd=%h required no strobe", pd);
        end else begin
          mon_e = exp_q.pop_front();
          if (pd !== mon_e) begin
            failures++;
            $display("FAIL tr_data: o_pd=%h required %h", pd, mon_e);
          end else begin
            seen[mon_e] = 1'b1;
          end
          pend_data  = mon_e;
          pend_valid = 1'b1;
        end
      end
      if (rdy === 1'b0) begin
        low_cnt++;
      end else if (low_cnt != 0) begin
        checks++;
        if (low_cnt != int'(PC)) begin
          failures++;
          $display("FAIL rdy_low_len: low for %0d cycles required %0d", low_cnt, PC);
        end
        low_cnt = 0;
      end
    end
  end

  task automatic test_reset;
    rst_n = 1'b0;
    mode  = 1'b0;
    din   = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (tr !== 1'b0)     begin failures++; $display("FAIL rst_tr: got %b required 0", tr); end
    checks++; if (pd !== 8'h00)    begin failures++; $display("FAIL rst_pd: got %h required 00", pd); end
    checks++; if (rdy !== 1'b1)    begin failures++; $display("FAIL rst_rdy: got %b required 1", rdy); end
    checks++; if (pdata !== 8'h00) begin failures++; $display("FAIL rst_data: got %h required 00", pdata); end
    checks++; if (rw !== 1'b0 || addr !== 1'b0) begin failures++; $display("FAIL rst_bus: rw=%b addr=%b required 0 0", rw, addr); end
    checks++; if (irq !== 1'b1)    begin failures++; $display("FAIL rst_irq: got %b required 1", irq); end
    checks++; if (rdp !== 8'h00 || wdp !== 8'h00) begin failures++; $display("FAIL rst_buses: rdata=%h wdata=%h required 00 00", rdp, wdp); end
  endtask

  task automatic test_poll_single;
    @(posedge clk); #1;
    din   = 8'h05;
    mode  = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      case (k)
        0: begin checks++; if (rw !== 1'b0 || addr !== 1'b0 || wdp !== 8'h00) begin failures++; $display("FAIL ps_dispatch: rw=%b addr=%b wdata=%h required 0 0 00", rw, addr, wdp); end end
        1: begin checks++; if (rw !== 1'b0 || addr !== 1'b0 || rdp !== 8'h80) begin failures++; $display("FAIL ps_poll: rw=%b addr=%b rdata=%h required 0 0 80", rw, addr, rdp); end end
        2: begin checks++; if (rw !== 1'b1 || addr !== 1'b1 || wdp !== 8'h05) begin failures++; $display("FAIL ps_wrbr: rw=%b addr=%b wdata=%h required 1 1 05", rw, addr, wdp); end end
        3: begin checks++; if (rw !== 1'b1 || addr !== 1'b0 || wdp !== 8'h00) begin failures++; $display("FAIL ps_clrsr: rw=%b addr=%b wdata=%h required 1 0 00", rw, addr, wdp); end end
        4: begin checks++; if (tr !== 1'b0) begin failures++; $display("FAIL ps_idle: o_tr=%b required 0", tr); end end
        5: begin checks++; if (tr !== 1'b1 || pd !== 8'h05) begin failures++; $display("FAIL ps_send: o_tr=%b o_pd=%h required 1 05", tr, pd); end end
        default: begin checks++; if (pdata !== 8'h05 || rdy !== 1'b0) begin failures++; $display("FAIL ps_print: o_data=%h o_rdy=%b required 05 0", pdata, rdy); end end
      endcase
    end
  endtask

  task automatic test_poll_stream;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int v = 0; v <= 20; v++) begin
      din = 8'(v);
      repeat (16) @(posedge clk);
      #1;
    end
    repeat (30) @(posedge clk);
    @(negedge clk);
    for (int v = 0; v <= 20; v++) begin
      checks++;
      if (!seen[v]) begin
        failures++;
        $display("FAIL stream_seen: byte %h printed=0 required 1", 8'(v));
      end
    end
    checks++;
    if (pdata !== 8'h14) begin
      failures++;
      $display("FAIL stream_last: o_data=%h required 14", pdata);
    end
  endtask

  task automatic test_irq_switch;
    bit found;
    @(posedge clk); #1;
    mode = 1'b1;
    din  = 8'h3C;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (rw === 1'b1 && addr === 1'b0 && wdp === 8'h81) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL irq_enable_write: no SR write of 81 seen, required one"); end
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (irq === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL irq_fall: o_irq=%b required 0", irq); end
    found = 1'b0;
    for (int n = 0; n < 4 && !found; n++) begin
      @(negedge clk);
      if (rw === 1'b1 && addr === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL irq_wrbr: no BR write after o_irq fell, required one"); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_low_at_wrbr: o_irq=%b required 0", irq); end
    @(negedge clk);
    checks++; if (rw !== 1'b1 || addr !== 1'b0 || wdp !== 8'h01 || irq !== 1'b0) begin failures++; $display("FAIL irq_clrsr: rw=%b addr=%b wdata=%h irq=%b required 1 0 01 0", rw, addr, wdp, irq); end
    @(negedge clk);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_rise: o_irq=%b required 1", irq); end
  endtask

  task automatic test_irq_busy;
    bit found;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (tr === 1'b1) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL busy_first_tr: no strobe seen, required one"); end
    @(posedge clk); #1;
    din = 8'hA5;
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      @(negedge clk);
      if (rw === 1'b1 && addr === 1'b1) found = 1'b1;
    end
    checks++; if (!found || wdp !== 8'hA5 || rdy !== 1'b0) begin failures++; $display("FAIL busy_wrbr: found=%b wdata=%h rdy=%b required 1 A5 0", found, wdp, rdy); end
    @(negedge clk);
    checks++; if (rw !== 1'b1 || addr !== 1'b0 || wdp !== 8'h01) begin failures++; $display("FAIL busy_clrsr: rw=%b addr=%b wdata=%h required 1 0 01", rw, addr, wdp); end
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        found = 1'b1;
      end else begin
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL busy_irq: o_irq=%b required 1", irq); end
        checks++; if (tr !== 1'b0)  begin failures++; $display("FAIL busy_tr: o_tr=%b required 0", tr); end
      end
    end
    checks++; if (!found || tr !== 1'b0) begin failures++; $display("FAIL busy_ready: rdy_seen=%b o_tr=%b required 1 0", found, tr); end
    @(negedge clk);
    checks++; if (tr !== 1'b1 || pd !== 8'hA5) begin failures++; $display("FAIL busy_send: o_tr=%b o_pd=%h required 1 A5", tr, pd); end
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      @(negedge clk);
      if (rdy === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin failures++; $display("FAIL rm_busy: o_rdy never 0, required 0"); end
    @(posedge clk); #1;
    rst_n = 1'b0;
    mode  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rdy !== 1'b1)    begin failures++; $display("FAIL rm_rdy: got %b required 1", rdy); end
    checks++; if (pdata !== 8'h00) begin failures++; $display("FAIL rm_data: got %h required 00", pdata); end
    checks++; if (tr !== 1'b0 || pd !== 8'h00 || irq !== 1'b1) begin failures++; $display("FAIL rm_outs: tr=%b pd=%h irq=%b required 0 00 1", tr, pd, irq); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rdp !== 8'h80) begin failures++; $display("FAIL rm_sr: SR read=%h required 80", rdp); end
    checks++; if (rdy !== 1'b1 || pdata !== 8'h00) begin failures++; $display("FAIL rm_after: rdy=%b o_data=%h required 1 00", rdy, pdata); end
  endtask

  initial begin
    test_reset;
    test_poll_single;
    test_poll_stream;
    test_irq_switch;
    test_irq_busy;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
